// File: rtl/interconn_rr_buffered_if.sv
// ============================================================================
//  Module      : interconn_rr_buffered_if
//  Description : Send/receive bundle of the buffered MVU crossbar.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface interconn_rr_buffered_if #(
    parameter int N     = 8,
    parameter int W     = 64,
    parameter int BADDR = 15
);
    logic [N*N-1:0]     send_to;
    logic [N-1:0]       send_en;
    logic [N*BADDR-1:0] send_addr;
    logic [N*W-1:0]     send_word;
    logic [N-1:0]       send_rdy;
    logic [N*N-1:0]     recv_from;
    logic [N-1:0]       recv_en;
    logic [N*BADDR-1:0] recv_addr;
    logic [N*W-1:0]     recv_word;
    logic               busy;

    modport master (
        output send_to, send_en, send_addr, send_word,
        input  send_rdy, recv_from, recv_en, recv_addr, recv_word, busy
    );

    modport slave (
        input  send_to, send_en, send_addr, send_word,
        output send_rdy, recv_from, recv_en, recv_addr, recv_word, busy
    );
endinterface

`default_nettype wire

// File: rtl/interconn_rr_buffered.sv
// ============================================================================
//  Module      : interconn_rr_buffered
//  Description : N x N multicast crossbar with per-source holding registers
//                and per-destination round-robin or static-priority arbiters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module interconn_rr_buffered #(
    parameter int N        = 8,
    parameter int W        = 64,
    parameter int BADDR    = 15,
    parameter int ARB_MODE = 1
) (
    input  logic                   clk,
    input  logic                   clr,
    interconn_rr_buffered_if.slave bus
);
    localparam int c_pw = (N > 1) ? $clog2(N) : 1;

    // Holding-register contents of every source, visible to all arbiters
    logic [N-1:0]     w_pend [N];
    logic [BADDR-1:0] w_addr [N];
    logic [W-1:0]     w_word [N];

    // Arbitration result of every destination, visible to all sources
    logic [N-1:0]     w_gnt;
    logic [c_pw-1:0]  w_sel  [N];

    logic             w_busy;

    // ------------------------------------------------------------------------
    // Source side: one-entry holding register per source
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < N; i++) begin : g_src
        logic [N-1:0]     r_pend;
        logic [BADDR-1:0] r_addr;
        logic [W-1:0]     r_word;
        logic [N-1:0]     w_retire;
        logic             w_accept;

        always_comb begin
            w_retire = '0;
            for (int j = 0; j < N; j++) begin
                w_retire[j] = w_gnt[j] && (w_sel[j] == c_pw'(i));
            end
        end

        // An empty mask is not a transfer; accepting it would never retire
        assign w_accept = bus.send_en[i] && (r_pend == '0) &&
                          (bus.send_to[i*N +: N] != '0);

        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                r_pend <= '0;
                r_addr <= '0;
                r_word <= '0;
            end else if (w_accept) begin
                r_pend <= bus.send_to[i*N +: N];
                r_addr <= bus.send_addr[i*BADDR +: BADDR];
                r_word <= bus.send_word[i*W +: W];
            end else begin
                r_pend <= r_pend & ~w_retire;
            end
        end

        assign w_pend[i]       = r_pend;
        assign w_addr[i]       = r_addr;
        assign w_word[i]       = r_word;
        assign bus.send_rdy[i] = (r_pend == '0);
    end

    // ------------------------------------------------------------------------
    // Destination side: arbiter, pointer and output register per destination
    // ------------------------------------------------------------------------
    for (genvar j = 0; j < N; j++) begin : g_dst
        logic [c_pw-1:0]  r_ptr;
        logic [c_pw-1:0]  w_sel_l;
        logic             w_gnt_l;
        logic [N-1:0]     w_onehot;
        logic [BADDR-1:0] w_addr_sel;
        logic [W-1:0]     w_word_sel;
        int               w_best_dist;

        logic             r_en;
        logic [N-1:0]     r_from;
        logic [BADDR-1:0] r_addr;
        logic [W-1:0]     r_word;

        // Winner is the requester closest to r_ptr walking downwards with wrap
        always_comb begin
            w_gnt_l     = 1'b0;
            w_sel_l     = '0;
            w_onehot    = '0;
            w_addr_sel  = '0;
            w_word_sel  = '0;
            w_best_dist = N;
            for (int i = 0; i < N; i++) begin
                if (w_pend[i][j] &&
                    (((int'(r_ptr) - i + N) % N) < w_best_dist)) begin
                    w_best_dist = (int'(r_ptr) - i + N) % N;
                    w_gnt_l     = 1'b1;
                    w_sel_l     = c_pw'(i);
                    w_onehot    = '0;
                    w_onehot[i] = 1'b1;
                    w_addr_sel  = w_addr[i];
                    w_word_sel  = w_word[i];
                end
            end
        end

        // Static-priority mode never moves the pointer off its own index
        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                r_ptr <= c_pw'(j);
            end else if ((ARB_MODE == 1) && w_gnt_l) begin
                r_ptr <= (w_sel_l == '0) ? c_pw'(N - 1) : (w_sel_l - c_pw'(1));
            end
        end

        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                r_en   <= 1'b0;
                r_from <= '0;
                r_addr <= '0;
                r_word <= '0;
            end else begin
                r_en <= w_gnt_l;
                if (w_gnt_l) begin
                    r_from <= w_onehot;
                    r_addr <= w_addr_sel;
                    r_word <= w_word_sel;
                end
            end
        end

        assign w_gnt[j]                        = w_gnt_l;
        assign w_sel[j]                        = w_sel_l;
        assign bus.recv_en[j]                  = r_en;
        assign bus.recv_from[j*N +: N]         = r_from;
        assign bus.recv_addr[j*BADDR +: BADDR] = r_addr;
        assign bus.recv_word[j*W +: W]         = r_word;
    end

    always_comb begin
        w_busy = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_busy = w_busy | (|w_pend[i]);
        end
    end

    assign bus.busy = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_interconn_rr_buffered.sv
// ============================================================================
//  Module      : tb_interconn_rr_buffered
//  Description : Directed bench for the crossbar, one round-robin and one
//                static-priority instance with N = 4.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_interconn_rr_buffered;
    localparam int N     = 4;
    localparam int W     = 64;
    localparam int BADDR = 15;
    localparam int NV    = 19;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    interconn_rr_buffered_if #(.N(N), .W(W), .BADDR(BADDR)) rr_if ();
    interconn_rr_buffered_if #(.N(N), .W(W), .BADDR(BADDR)) pr_if ();

    logic [N-1:0]       rr_en,   pr_en;
    logic [N*N-1:0]     rr_to,   pr_to;
    logic [N*BADDR-1:0] rr_addr, pr_addr;
    logic [N*W-1:0]     rr_word, pr_word;

    assign rr_if.send_en   = rr_en;
    assign rr_if.send_to   = rr_to;
    assign rr_if.send_addr = rr_addr;
    assign rr_if.send_word = rr_word;
    assign pr_if.send_en   = pr_en;
    assign pr_if.send_to   = pr_to;
    assign pr_if.send_addr = pr_addr;
    assign pr_if.send_word = pr_word;

    interconn_rr_buffered #(.N(N), .W(W), .BADDR(BADDR), .ARB_MODE(1)) u_rr (
        .clk (clk),
        .clr (clr),
        .bus (rr_if)
    );

    interconn_rr_buffered #(.N(N), .W(W), .BADDR(BADDR), .ARB_MODE(0)) u_pr (
        .clk (clk),
        .clr (clr),
        .bus (pr_if)
    );

    typedef struct {
        logic [N-1:0]   en;
        logic [N*N-1:0] to;
        logic [N-1:0]   rdy;
        logic [N-1:0]   ren;
        logic [N*N-1:0] from;
        logic           busy;
    } vec_t;

    vec_t               vecs [NV];
    int                 n_total = 0;
    int                 n_bad   = 0;
    logic [N*BADDR-1:0] addr_all;
    logic [N*W-1:0]     word_all;
    int                 pr_order [6];
    logic [N-1:0]       exp_nib;
    logic [W-1:0]       w1, w2;

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r = 0;
        for (int k = 0; k < N; k++) if (v[k]) r = k;
        return r;
    endfunction

    initial begin
        addr_all = {15'h0333, 15'h0222, 15'h0111, 15'h0010};
        word_all = {64'hCAFE_0000_0000_0003, 64'hDEAD_BEEF_0000_0002,
                    64'h1111_2222_3333_4444, 64'h0000_0000_0000_00A5};
        w1 = 64'h0123_4567_89AB_CDEF;
        w2 = 64'hFEDC_BA98_7654_3210;

        //                en       to        rdy      ren      from      busy
        vecs[0]  = '{4'b0001, 16'h0002, 4'b1110, 4'b0000, 16'h0000, 1'b1};
        vecs[1]  = '{4'b0000, 16'h0000, 4'b1111, 4'b0010, 16'h0010, 1'b0};
        vecs[2]  = '{4'b0000, 16'h0000, 4'b1111, 4'b0000, 16'h0010, 1'b0};
        vecs[3]  = '{4'b0100, 16'h0B00, 4'b1011, 4'b0000, 16'h0010, 1'b1};
        vecs[4]  = '{4'b0000, 16'h0000, 4'b1111, 4'b1011, 16'h4044, 1'b0};
        vecs[5]  = '{4'b0000, 16'h0000, 4'b1111, 4'b0000, 16'h4044, 1'b0};
        vecs[6]  = '{4'b0010, 16'h0000, 4'b1111, 4'b0000, 16'h4044, 1'b0};
        vecs[7]  = '{4'b0000, 16'h0000, 4'b1111, 4'b0000, 16'h4044, 1'b0};
        vecs[8]  = '{4'b1111, 16'h4444, 4'b0000, 4'b0000, 16'h4044, 1'b1};
        vecs[9]  = '{4'b1111, 16'h4444, 4'b0100, 4'b0100, 16'h4444, 1'b1};
        vecs[10] = '{4'b1111, 16'h4444, 4'b0010, 4'b0100, 16'h4244, 1'b1};
        vecs[11] = '{4'b1111, 16'h4444, 4'b0001, 4'b0100, 16'h4144, 1'b1};
        vecs[12] = '{4'b1111, 16'h4444, 4'b1000, 4'b0100, 16'h4844, 1'b1};
        vecs[13] = '{4'b1111, 16'h4444, 4'b0100, 4'b0100, 16'h4444, 1'b1};
        vecs[14] = '{4'b1111, 16'h4444, 4'b0010, 4'b0100, 16'h4244, 1'b1};
        vecs[15] = '{4'b0000, 16'h0000, 4'b0011, 4'b0100, 16'h4144, 1'b1};
        vecs[16] = '{4'b0000, 16'h0000, 4'b1011, 4'b0100, 16'h4844, 1'b1};
        vecs[17] = '{4'b0000, 16'h0000, 4'b1111, 4'b0100, 16'h4444, 1'b0};
        vecs[18] = '{4'b0000, 16'h0000, 4'b1111, 4'b0000, 16'h4444, 1'b0};

        pr_order = '{2, 1, 2, 1, 2, 1};

        clr     = 1'b1;
        rr_en   = '0; rr_to = '0; rr_addr = addr_all; rr_word = word_all;
        pr_en   = '0; pr_to = '0; pr_addr = addr_all; pr_word = word_all;
        #12;
        check("reset rr rdy",  rr_if.send_rdy,  4'b1111);
        check("reset rr busy", rr_if.busy,      1'b0);
        check("reset rr ren",  rr_if.recv_en,   4'b0000);
        check("reset rr from", rr_if.recv_from, 16'h0000);
        check("reset rr addr", rr_if.recv_addr, '0);
        check("reset rr word", rr_if.recv_word, '0);
        check("reset pr rdy",  pr_if.send_rdy,  4'b1111);
        check("reset pr busy", pr_if.busy,      1'b0);
        clr = 1'b0;

        // Unicast, multicast, empty mask and round-robin contention
        for (int v = 0; v < NV; v++) begin
            rr_en = vecs[v].en;
            rr_to = vecs[v].to;
            tick();
            check($sformatf("v%0d rdy", v),  rr_if.send_rdy,  vecs[v].rdy);
            check($sformatf("v%0d ren", v),  rr_if.recv_en,   vecs[v].ren);
            check($sformatf("v%0d from", v), rr_if.recv_from, vecs[v].from);
            check($sformatf("v%0d busy", v), rr_if.busy,      vecs[v].busy);
            for (int j = 0; j < N; j++) begin
                if (vecs[v].ren[j]) begin
                    int s;
                    s = onehot_idx(vecs[v].from[j*N +: N]);
                    check($sformatf("v%0d addr d%0d", v, j),
                          rr_if.recv_addr[j*BADDR +: BADDR], addr_all[s*BADDR +: BADDR]);
                    check($sformatf("v%0d word d%0d", v, j),
                          rr_if.recv_word[j*W +: W], word_all[s*W +: W]);
                end
            end
        end

        // Static priority: src2 wins dest2 whenever it requests
        pr_en = 4'b1111;
        pr_to = 16'h4444;
        tick();
        check("prio accept rdy", pr_if.send_rdy, 4'b0000);
        for (int k = 0; k < 6; k++) begin
            tick();
            exp_nib = 4'b0001 << pr_order[k];
            check($sformatf("prio g%0d ren2", k), pr_if.recv_en[2], 1'b1);
            check($sformatf("prio g%0d from2", k), pr_if.recv_from[11:8], exp_nib);
        end
        pr_en = '0;
        for (int k = 0; k < 4; k++) tick();
        check("prio drain busy", pr_if.busy, 1'b0);

        // Partial multicast: dest1 delivers at once, dest0 after src0 yields
        pr_en = 4'b0011;
        pr_to = 16'h0031;
        tick();
        check("pmc e0 rdy", pr_if.send_rdy, 4'b1100);
        pr_en = 4'b0001;
        tick();
        check("pmc e1 ren",   pr_if.recv_en,         4'b0011);
        check("pmc e1 from0", pr_if.recv_from[3:0],  4'b0001);
        check("pmc e1 from1", pr_if.recv_from[7:4],  4'b0010);
        check("pmc e1 addr1", pr_if.recv_addr[2*BADDR-1:BADDR], addr_all[2*BADDR-1:BADDR]);
        check("pmc e1 rdy",   pr_if.send_rdy,        4'b1101);
        tick();
        check("pmc e2 ren",   pr_if.recv_en,         4'b0001);
        check("pmc e2 from0", pr_if.recv_from[3:0],  4'b0010);
        check("pmc e2 word0", pr_if.recv_word[W-1:0], word_all[2*W-1:W]);
        check("pmc e2 rdy",   pr_if.send_rdy,        4'b1110);
        pr_en = '0;
        tick();
        check("pmc e3 ren",   pr_if.recv_en,         4'b0001);
        check("pmc e3 from0", pr_if.recv_from[3:0],  4'b0001);
        check("pmc e3 busy",  pr_if.busy,            1'b0);
        tick();
        check("pmc e4 ren",   pr_if.recv_en,         4'b0000);

        // Back-pressure: a new word offered while not ready waits its turn
        rr_en = 4'b1000;
        rr_to = 16'h1000;
        rr_word[3*W +: W] = w1;
        tick();
        check("bp e0 rdy", rr_if.send_rdy, 4'b0111);
        rr_word[3*W +: W] = w2;
        tick();
        check("bp e1 ren",  rr_if.recv_en,        4'b0001);
        check("bp e1 word", rr_if.recv_word[W-1:0], w1);
        check("bp e1 rdy",  rr_if.send_rdy,       4'b1111);
        tick();
        check("bp e2 ren",  rr_if.recv_en,        4'b0000);
        check("bp e2 rdy",  rr_if.send_rdy,       4'b0111);
        rr_en = '0;
        tick();
        check("bp e3 ren",  rr_if.recv_en,        4'b0001);
        check("bp e3 word", rr_if.recv_word[W-1:0], w2);
        check("bp e3 from", rr_if.recv_from[3:0], 4'b1000);
        tick();
        check("bp e4 ren",  rr_if.recv_en,        4'b0000);
        rr_word = word_all;

        // Asynchronous clear with three sources pending on dest3
        rr_en = 4'b0111;
        rr_to = 16'h0888;
        tick();
        check("clr e0 rdy", rr_if.send_rdy, 4'b1000);
        rr_en = '0;
        tick();
        check("clr e1 ren", rr_if.recv_en, 4'b1000);
        #3;
        clr = 1'b1;
        #1;
        check("clr ren",  rr_if.recv_en,   4'b0000);
        check("clr from", rr_if.recv_from, 16'h0000);
        check("clr addr", rr_if.recv_addr, '0);
        check("clr word", rr_if.recv_word, '0);
        check("clr rdy",  rr_if.send_rdy,  4'b1111);
        check("clr busy", rr_if.busy,      1'b0);
        #2;
        clr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("post clr ren %0d", k), rr_if.recv_en, 4'b0000);
        end
        check("post clr busy", rr_if.busy, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/interconn_rr_buffered.md
Name: interconn_rr_buffered

Overview:
- Next-generation MVU-to-MVU crossbar: N sources by N destinations, with multicast.
- Each source has a one-entry holding register with a ready/valid handshake. Senders are back-pressured instead of silently losing words.
- Each destination arbitrates among pending sources using either rotating round-robin or legacy static priority (selected by a parameter).
- A multicast word is retired only once every addressed destination has taken it. Sits between the MVU send ports and the MVU remote-write ports.

Parameters:
- N, 8, number of MVUs (sources = destinations); N >= 1
- W, 64, data word width
- BADDR, 15, destination memory address width
- ARB_MODE, 1, 0 = static priority (destination-relative), 1 = round-robin

Ports:
- clk  in  1  clock
- clr  in  1  reset, asynchronous, active-high
- send_to  in  N*N  source i bits [i*N +: N]: destination select mask
- send_en  in  N  source i presents a word
- send_addr  in  N*BADDR  source i address, slice [i*BADDR +: BADDR]
- send_word  in  N*W  source i data, slice [i*W +: W]
- send_rdy  out  N  source i holding register can accept
- recv_from  out  N*N  destination j bits [j*N +: N]: one-hot source of delivered word
- recv_en  out  N  destination j write strobe
- recv_addr  out  N*BADDR  destination j address
- recv_word  out  N*W  destination j data
- busy  out  1  any holding register has pending destinations

Behaviour:
- Reset values:
  - all recv_* = 0; busy = 0.
  - every pending mask pend[i] = 0, so send_rdy = all ones.
  - destination pointers ptr[j] = j.
- Holding register per source i: stores addr, word, and pend[i] (N bits, one per destination).
- Handshake:
  - send_rdy[i] = (pend[i] == 0), combinational from registers only.
  - Accept at a rising edge when send_en[i] & send_rdy[i] & (send_to[i] != 0): capture addr and word, set pend[i] = send_to[i].
  - send_en with send_to == 0 is ignored: no capture, no output.
  - send_en while send_rdy = 0 is ignored; the source must hold its request.
- Requests: req[j][i] = pend[i][j].
- Arbitration (combinational), per destination j:
  - Search order is ptr[j], ptr[j]-1, ..., wrapping from 0 to N-1.
  - The first requesting source is sel[j]; gnt[j] = |req[j].
- Pointer update:
  - ARB_MODE = 1: on a grant, ptr[j] <= (sel[j] == 0) ? N-1 : sel[j]-1.
  - ARB_MODE = 0: ptr[j] is constant at j.
  - With no grant, ptr[j] is held.
- Output registers (each edge, per destination j):
  - recv_en[j] <= gnt[j].
  - If gnt[j]: recv_from[j] <= 1 << sel[j]; recv_addr[j] and recv_word[j] load from holding register sel[j].
  - If no grant: recv_from, recv_addr and recv_word hold their previous values.
- Retire: on the same edge, for every j with gnt[j], clear pend[sel[j]][j].
  - A source becomes ready once all its bits are cleared.
  - A new accept on that source is possible in the next cycle; there is no same-edge refill.
- Latency:
  - A word accepted at edge t appears on recv_* after edge t+1 at the earliest.
  - Multicast to k uncontended destinations completes at edge t+1 for all k simultaneously.
- Contention:
  - Each destination grants at most one source per cycle.
  - Different destinations may grant the same source in the same cycle; multicast fan-out happens in parallel.
  - Sources waiting on a destination keep send_rdy = 0.
  - In round-robin mode each requester is served within N grants of that destination.
- busy = |pend (all sources), registered-derived.
- N == 1: same logic; the pointer is fixed at 0. No special direct path.
- clr mid-transfer: all pending words are discarded and all outputs are zeroed immediately (asynchronous). Nothing is delivered after clr deasserts until a new accept.

Test Plan:
1. N=4, ARB_MODE=1: src0 sends to=0b0010, addr=0x10, word=0xA5 at edge 0 -> send_rdy[0] low for one cycle; after edge 1: recv_en[1]=1, recv_from[1]=0b0001, recv_addr[1]=0x10, recv_word[1]=0xA5; send_rdy[0] high again.
2. Multicast: src2 sends to=0b1011 -> after edge 1, recv_en = 1 on destinations 0, 1 and 3 with identical addr and word, recv_from = 0b0100 on each; pend[2] cleared in one cycle.
3. Round-robin: src0..src3 all continuously target destination 2 -> grant order 2,1,0,3,2,1,... and each src sees exactly one grant per 4 cycles. Rerun with ARB_MODE=0 -> src2 wins every time it requests; a lower-priority source waits.
4. Partial multicast: src1 to=0b0011 while src0 hogs destination 0 (to=0b0001, priority mode) -> destination 1 receives at edge 1; src1 stays not-ready until destination 0 grants it; no duplicate recv_en on destination 1.
5. Back-pressure: src3 holds send_en with a new word while send_rdy[3]=0 -> word not captured; captured on the first edge with send_rdy[3]=1, and every word is delivered exactly once.
6. Reset: assert clr asynchronously while 3 sources are pending -> recv_* = 0, send_rdy = 1111 and busy = 0 immediately; no recv_en pulses after release without new sends. send_en with send_to = 0 -> no output and send_rdy stays high.
